// File: rtl/ofdm_pkg.sv
// OFDM frame controller shared definitions.
// Mapper byte/carrier geometry and the frame FSM encoding.
package ofdm_pkg;

  localparam int B             = 8;
  localparam int N             = 8;
  localparam int LOG2M         = 4;
  localparam int BYTES_PER_SYM = N * LOG2M / B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DRAIN,
    S_GAP
  } state_t;

endpackage

// File: rtl/ofdm_sym_counter.sv
// Byte-within-symbol and symbol counters for the mapper stream.
// wrap pulses on the transfer that completes a symbol.
module ofdm_sym_counter #(
  parameter int BPS = ofdm_pkg::BYTES_PER_SYM
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] sym_cnt,
  output logic       wrap
);

  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] sym_cnt_q, sym_cnt_d;

  assign wrap    = en && (byte_cnt_q == 8'(BPS - 1));
  assign sym_cnt = sym_cnt_q;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    sym_cnt_d  = sym_cnt_q;
    if (en) begin
      if (wrap) begin
        byte_cnt_d = '0;
        sym_cnt_d  = sym_cnt_q + 8'd1;
      end else begin
        byte_cnt_d = byte_cnt_q + 8'd1;
      end
    end
    // clear wins so the preamble's final wrap restarts the data count
    if (clr) begin
      byte_cnt_d = '0;
      sym_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      sym_cnt_q  <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      sym_cnt_q  <= sym_cnt_d;
    end
  end

endmodule

// File: rtl/ofdm_frame_ctrl.sv
// OFDM frame controller: preamble, payload pass-through, drain, gap.
// Feeds the QAM mapper and tracks its per-symbol fft_last pulses.
module ofdm_frame_ctrl #(
  parameter int           B          = ofdm_pkg::B,
  parameter int           N          = ofdm_pkg::N,
  parameter int           LOG2M      = ofdm_pkg::LOG2M,
  parameter int           PRE_SYMS   = 2,
  parameter logic [B-1:0] PRE_BYTE   = 'hA5,
  parameter logic [7:0]   PILOT_MASK = 8'hFF,
  parameter int           GAP_CYCLES = 16,
  localparam int          BYTES_PER_SYM = N * LOG2M / B
) (
  input  logic         aclk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   frame_len,
  input  logic [7:0]   data_mask,
  input  logic [B-1:0] s_data_in,
  input  logic         s_dvalid,
  output logic         s_dready,
  output logic [B-1:0] m_data_out,
  output logic         m_dvalid,
  input  logic         m_dready,
  input  logic         fft_last,
  output logic [7:0]   carrier_control,
  output logic         busy,
  output logic         frame_done,
  output logic         underrun
);

  import ofdm_pkg::*;

  state_t      state_q, state_d;
  logic [7:0]  frame_len_q, frame_len_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  last_cnt_q, last_cnt_d;
  logic [7:0]  carrier_q, carrier_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic        underrun_q, underrun_d;
  logic        frame_done_q, frame_done_d;

  logic        xfer;
  logic        cnt_clr;
  logic        wrap;
  logic [7:0]  sym_cnt;
  logic [8:0]  target;

  ofdm_sym_counter #(
    .BPS (BYTES_PER_SYM)
  ) u_cnt (
    .clk     (aclk),
    .rst     (reset),
    .clr     (cnt_clr),
    .en      (xfer),
    .sym_cnt (sym_cnt),
    .wrap    (wrap)
  );

  // payload path is combinational so DATA adds no latency
  always_comb begin
    m_data_out = '0;
    m_dvalid   = 1'b0;
    s_dready   = 1'b0;
    unique case (state_q)
      S_PREAMBLE: begin
        m_data_out = PRE_BYTE;
        m_dvalid   = 1'b1;
      end
      S_DATA: begin
        m_data_out = s_data_in;
        m_dvalid   = s_dvalid;
        s_dready   = m_dready;
      end
      default: ;
    endcase
  end

  assign xfer   = m_dvalid & m_dready;
  assign target = {1'b0, frame_len_q} + 9'(PRE_SYMS);

  always_comb begin
    state_d      = state_q;
    frame_len_d  = frame_len_q;
    mask_d       = mask_q;
    last_cnt_d   = last_cnt_q;
    carrier_d    = carrier_q;
    gap_cnt_d    = gap_cnt_q;
    underrun_d   = underrun_q;
    frame_done_d = 1'b0;
    cnt_clr      = 1'b0;

    if (state_q != S_IDLE && fft_last) begin
      if (last_cnt_q != 8'hFF) last_cnt_d = last_cnt_q + 8'd1;
      if ({1'b0, last_cnt_d} >= 9'(PRE_SYMS)) carrier_d = mask_q;
      else carrier_d = PILOT_MASK;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_PREAMBLE;
          frame_len_d = frame_len;
          mask_d      = data_mask;
          last_cnt_d  = '0;
          underrun_d  = 1'b0;
          carrier_d   = PILOT_MASK;
          cnt_clr     = 1'b1;
        end
      end
      S_PREAMBLE: begin
        if (wrap && sym_cnt == 8'(PRE_SYMS - 1)) begin
          cnt_clr = 1'b1;
          state_d = (frame_len_q != 8'd0) ? S_DATA : S_DRAIN;
        end
      end
      S_DATA: begin
        if (m_dready && !s_dvalid) underrun_d = 1'b1;
        if (wrap && sym_cnt == frame_len_q - 8'd1) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // wait for the mapper to emit every symbol of the frame
        if ({1'b0, last_cnt_d} >= target) begin
          frame_done_d = 1'b1;
          gap_cnt_d    = '0;
          state_d      = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + 16'd1;
        if (gap_cnt_q == 16'(GAP_CYCLES - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      frame_len_q  <= '0;
      mask_q       <= '0;
      last_cnt_q   <= '0;
      carrier_q    <= '0;
      gap_cnt_q    <= '0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_len_q  <= frame_len_d;
      mask_q       <= mask_d;
      last_cnt_q   <= last_cnt_d;
      carrier_q    <= carrier_d;
      gap_cnt_q    <= gap_cnt_d;
      underrun_q   <= underrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign carrier_control = carrier_q;
  assign busy            = (state_q != S_IDLE);
  assign frame_done      = frame_done_q;
  assign underrun        = underrun_q;

endmodule

// File: tb/tb_ofdm_frame_ctrl.sv
// Bench for ofdm_frame_ctrl: byte scoreboard plus a small mapper
// model that returns fft_last two cycles after each symbol.
module tb_ofdm_frame_ctrl;

  logic       aclk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] frame_len = '0;
  logic [7:0] data_mask = '0;
  logic [7:0] s_data_in = 8'h10;
  logic       s_dvalid = 1'b1;
  logic       m_dready = 1'b1;
  logic       fft_last = 1'b0;
  logic       s_dready;
  logic [7:0] m_data_out;
  logic       m_dvalid;
  logic [7:0] carrier_control;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  ofdm_frame_ctrl dut (
    .aclk            (aclk),
    .reset           (reset),
    .start           (start),
    .frame_len       (frame_len),
    .data_mask       (data_mask),
    .s_data_in       (s_data_in),
    .s_dvalid        (s_dvalid),
    .s_dready        (s_dready),
    .m_data_out      (m_data_out),
    .m_dvalid        (m_dvalid),
    .m_dready        (m_dready),
    .fft_last        (fft_last),
    .carrier_control (carrier_control),
    .busy            (busy),
    .frame_done      (frame_done),
    .underrun        (underrun)
  );

  always #5 aclk = ~aclk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  int         nx = 0;
  int         nl = 0;
  int         target = 0;
  int         fft_sched = 0;
  int         fd_cnt = 0;
  int         p = 0;
  logic       fd_exp = 1'b0;
  logic       in_frame = 1'b0;
  logic       hole_chk = 1'b0;
  logic       sdr_seen = 1'b0;
  logic       busy_s = 1'b0;
  logic       rand_rdy = 1'b0;
  logic [7:0] cur_mask = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mvalid"}, m_dvalid, 0);
    chk({tag, "_sready"}, s_dready, 0);
    chk({tag, "_mdata"}, m_data_out, 0);
    chk({tag, "_carrier"}, carrier_control, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fdone"}, frame_done, 0);
    chk({tag, "_underrun"}, underrun, 0);
  endtask

  // one clock: sample at negedge, drive inputs 1 after posedge
  task automatic cyc();
    logic [7:0] e;
    logic       acc;
    @(negedge aclk);
    busy_s = busy;
    if (s_dready) sdr_seen = 1'b1;
    if (frame_done) fd_cnt++;
    if (in_frame) begin
      chk("frame_done", frame_done, fd_exp);
      chk("carrier", carrier_control, (nl >= 2) ? cur_mask : 8'hFF);
    end
    if (hole_chk) chk("hole_mvalid", m_dvalid, 0);
    acc = s_dvalid & s_dready;
    if (m_dvalid & m_dready) begin
      chk("sb_underflow", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("m_data", m_data_out, e);
      end
      nx++;
      if (nx % 4 == 0) fft_sched = 2;
    end
    @(posedge aclk);
    if (in_frame && fft_last) begin
      nl++;
      fd_exp = (nl == target);
    end else begin
      fd_exp = 1'b0;
    end
    #1;
    if (acc) begin
      p++;
      s_data_in = 8'(8'h10 + p);
    end
    fft_last = 1'b0;
    if (fft_sched > 0) begin
      fft_sched--;
      if (fft_sched == 0) fft_last = 1'b1;
    end
    if (rand_rdy) m_dready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_frame(input logic [7:0] len,
                             input logic [7:0] mask);
    frame_len = len;
    data_mask = mask;
    start     = 1'b1;
    cur_mask  = mask;
    target    = 2 + int'(len);
    nx        = 0;
    nl        = 0;
    fd_exp    = 1'b0;
    sdr_seen  = 1'b0;
    fft_sched = 0;
    repeat (8) exp_q.push_back(8'hA5);
    for (int k = 0; k < int'(len) * 4; k++)
      exp_q.push_back(8'(8'h10 + p + k));
    cyc();
    start     = 1'b0;
    frame_len = 8'hEE;
    data_mask = 8'h55;
    in_frame  = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] len,
                           input logic [7:0] mask,
                           input int start_at,
                           input int hole_at,
                           input logic exp_und);
    int   n;
    int   gap;
    int   f0;
    logic poked;
    logic holed;
    start_frame(len, mask);
    f0    = fd_cnt;
    poked = 1'b0;
    holed = 1'b0;
    n     = 0;
    while (fd_cnt == f0 && n < 3000) begin
      if (start_at != 0 && nx == start_at && !poked) begin
        start     = 1'b1;
        frame_len = 8'd1;
        cyc();
        start = 1'b0;
        poked = 1'b1;
      end else if (hole_at != 0 && nx == hole_at && !holed) begin
        s_dvalid = 1'b0;
        hole_chk = 1'b1;
        repeat (3) cyc();
        s_dvalid = 1'b1;
        hole_chk = 1'b0;
        holed    = 1'b1;
      end else begin
        cyc();
      end
      n++;
    end
    chk("frame_done_seen", fd_cnt - f0, 1);
    gap = 1;
    cyc();
    while (busy_s && gap < 100) begin
      gap++;
      cyc();
    end
    chk("gap_len", gap, 16);
    chk("fd_count", fd_cnt - f0, 1);
    chk("sb_empty", exp_q.size(), 0);
    chk("underrun", underrun, exp_und);
    in_frame = 1'b0;
  endtask

  initial begin
    int n;
    int f0;
    repeat (2) @(posedge aclk);
    #1;
    chk_zero("reset");
    reset = 1'b0;
    cyc();
    cyc();

    run_frame(8'd3, 8'h0E, 0, 0, 1'b0);

    run_frame(8'd0, 8'h0E, 0, 0, 1'b0);
    chk("no_sdready", sdr_seen, 0);

    run_frame(8'd3, 8'h0E, 0, 10, 1'b1);
    repeat (3) cyc();
    chk("underrun_sticky", underrun, 1);

    rand_rdy = 1'b1;
    run_frame(8'd2, 8'h3C, 9, 0, 1'b0);
    rand_rdy = 1'b0;
    m_dready = 1'b1;
    repeat (4) cyc();
    chk("start_ignored", busy_s, 0);

    start_frame(8'd3, 8'h0E);
    n = 0;
    while (nx != 10 && n < 200) begin
      cyc();
      n++;
    end
    chk("reach_data", nx, 10);
    f0    = fd_cnt;
    reset = 1'b1;
    #1;
    chk_zero("midreset");
    exp_q.delete();
    nx        = 0;
    fft_sched = 0;
    fft_last  = 1'b0;
    in_frame  = 1'b0;
    fd_exp    = 1'b0;
    @(posedge aclk);
    #1;
    reset = 1'b0;
    repeat (5) cyc();
    chk("no_fd_after_reset", fd_cnt - f0, 0);

    run_frame(8'd1, 8'h3C, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
